// File: rtl/pipe_scoreboard_pkg.sv
// Shared types for the ID-stage scoreboard: in-flight entry layout, default
// geometry and the forward-select encoding.
package pipe_scoreboard_pkg;

  localparam int SB_DEPTH_DEFAULT      = 3;
  localparam int SB_LOAD_READY_DEFAULT = 1;
  // Destination tags are stored at a fixed width so one struct serves any REG_W up to 8.
  localparam int SB_DEST_W             = 8;

  typedef struct packed {
    logic                 valid;
    logic                 writes;
    logic                 is_load;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  function automatic logic entry_live(input sb_entry_t e);
    return e.valid & e.writes;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Signal bundle between the ID stage and the scoreboard: decoded control word
// in, forward selects and interlock out.
interface pipe_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int SEL_W    = 2
);
  logic                id_valid;
  logic [REG_W-1:0]    id_sr1;
  logic [REG_W-1:0]    id_sr2;
  logic                id_uses_sr1;
  logic                id_uses_sr2;
  logic                id_writes_dest;
  logic [REG_W-1:0]    id_dest;
  logic                id_is_load;
  logic                mem_stall;
  logic                flush;

  logic                issue;
  logic                hazard_stall;
  logic [SEL_W-1:0]    fwd_sel_a;
  logic [SEL_W-1:0]    fwd_sel_b;
  logic [NUM_REGS-1:0] busy_mask;
  logic [15:0]         hazard_cycles;

  modport master (
    output id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
           id_writes_dest, id_dest, id_is_load, mem_stall, flush,
    input  issue, hazard_stall, fwd_sel_a, fwd_sel_b, busy_mask, hazard_cycles
  );

  modport slave (
    input  id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
           id_writes_dest, id_dest, id_is_load, mem_stall, flush,
    output issue, hazard_stall, fwd_sel_a, fwd_sel_b, busy_mask, hazard_cycles
  );
endinterface

// File: rtl/pipe_scoreboard_match_prio.sv
// Priority picker over per-entry match bits; the lowest index (youngest
// in-flight instruction) wins.
module sb_match_prio #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] match,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        idx = IDX_W'(k);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard for the LC-3b pipeline: a shift register of
// in-flight destination tags beside ID, driving forward selects and the load-use stall.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int REG_W       = 3,
  parameter int DEPTH       = SB_DEPTH_DEFAULT,
  parameter int LOAD_READY  = SB_LOAD_READY_DEFAULT,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipe_scoreboard_if.slave sb
);

  sb_entry_t           entries [DEPTH];
  sb_entry_t           id_entry;
  logic [DEPTH-1:0]    match_a;
  logic [DEPTH-1:0]    match_b;
  logic [DEPTH-1:0]    early_load;
  logic [SEL_W-1:0]    idx_a;
  logic [SEL_W-1:0]    idx_b;
  logic                hit_a;
  logic                hit_b;
  logic                raw;
  logic                hazard_stall;
  logic                issue;
  logic [NUM_REGS-1:0] busy;
  logic [15:0]         hazard_cycles;

  // early_load marks loads whose data is not yet available for forwarding.
  always_comb begin
    match_a    = '0;
    match_b    = '0;
    early_load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k]    = entry_live(entries[k]) && sb.id_uses_sr1 &&
                      (entries[k].dest == SB_DEST_W'(sb.id_sr1));
      match_b[k]    = entry_live(entries[k]) && sb.id_uses_sr2 &&
                      (entries[k].dest == SB_DEST_W'(sb.id_sr2));
      early_load[k] = entries[k].is_load && (k < LOAD_READY);
    end
  end

  sb_match_prio #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_prio_a (
    .match (match_a),
    .idx   (idx_a),
    .hit   (hit_a)
  );

  sb_match_prio #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_prio_b (
    .match (match_b),
    .idx   (idx_b),
    .hit   (hit_b)
  );

  always_comb begin
    raw          = sb.id_valid &&
                   ((hit_a && early_load[idx_a]) || (hit_b && early_load[idx_b]));
    hazard_stall = raw && !sb.flush;
    issue        = sb.id_valid && !hazard_stall && !sb.mem_stall && !sb.flush;

    id_entry         = '0;
    id_entry.valid   = issue;
    id_entry.writes  = issue && sb.id_writes_dest;
    id_entry.is_load = issue && sb.id_is_load;
    id_entry.dest    = issue ? SB_DEST_W'(sb.id_dest) : '0;

    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (entry_live(entries[k]) && (entries[k].dest == SB_DEST_W'(r))) begin
          busy[r] = 1'b1;
        end
      end
    end
  end

  // The whole scoreboard freezes under mem_stall; a flush clears the youngest slots after the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= '0;
      end
      hazard_cycles <= '0;
    end else if (!sb.mem_stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0] <= id_entry;
      if (sb.flush) begin
        for (int k = 0; k < FLUSH_DEPTH && k < DEPTH; k++) begin
          entries[k] <= '0;
        end
      end
      if (hazard_stall && (hazard_cycles != 16'hFFFF)) begin
        hazard_cycles <= hazard_cycles + 16'd1;
      end
    end
  end

  assign sb.issue         = issue;
  assign sb.hazard_stall  = hazard_stall;
  assign sb.fwd_sel_a     = hit_a ? (idx_a + SEL_W'(1)) : SEL_W'(FWD_RF);
  assign sb.fwd_sel_b     = hit_b ? (idx_b + SEL_W'(1)) : SEL_W'(FWD_RF);
  assign sb.busy_mask     = busy;
  assign sb.hazard_cycles = hazard_cycles;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: an in-flight instruction list model is
// compared every cycle, with literal expectations pinning key scenarios.
module tb_pipe_scoreboard;
  import pipe_scoreboard_pkg::*;

  localparam int NUM_REGS    = 8;
  localparam int REG_W       = 3;
  localparam int DEPTH       = 3;
  localparam int LOAD_READY  = 1;
  localparam int FLUSH_DEPTH = 1;
  localparam int SEL_W       = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  pipe_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .SEL_W(SEL_W)) sb ();

  pipe_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .DEPTH(DEPTH),
    .LOAD_READY(LOAD_READY), .FLUSH_DEPTH(FLUSH_DEPTH), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  // Model: only instructions that write a register matter; age 0 = EX.
  typedef struct {
    int age;
    int dest;
    bit is_load;
  } inflight_t;

  inflight_t inflight[$];
  int        model_hc = 0;
  bit        exp_issue;
  bit        exp_stall;
  int        exp_sel_a;
  int        exp_sel_b;
  int        exp_busy;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic youngestWriter(input int r, input bit uses, output bit found,
                                output int age, output bit is_load);
    found   = 1'b0;
    age     = 0;
    is_load = 1'b0;
    if (uses) begin
      foreach (inflight[i]) begin
        if (inflight[i].dest == r && (!found || inflight[i].age < age)) begin
          found   = 1'b1;
          age     = inflight[i].age;
          is_load = inflight[i].is_load;
        end
      end
    end
  endtask

  task automatic evalModel();
    bit fa, fb, la, lb;
    int aa, ab;
    bit load_use;
    exp_busy = 0;
    foreach (inflight[i]) exp_busy = exp_busy | (1 << inflight[i].dest);
    youngestWriter(int'(sb.id_sr1), sb.id_uses_sr1, fa, aa, la);
    youngestWriter(int'(sb.id_sr2), sb.id_uses_sr2, fb, ab, lb);
    exp_sel_a = fa ? aa + 1 : 0;
    exp_sel_b = fb ? ab + 1 : 0;
    load_use  = sb.id_valid && ((fa && la && aa < LOAD_READY) || (fb && lb && ab < LOAD_READY));
    exp_stall = load_use && !sb.flush;
    exp_issue = sb.id_valid && !exp_stall && !sb.mem_stall && !sb.flush;
  endtask

  task automatic advanceModel();
    inflight_t nxt[$];
    inflight_t item;
    if (!rst_n) begin
      inflight.delete();
      model_hc = 0;
    end else if (!sb.mem_stall) begin
      foreach (inflight[i]) begin
        item     = inflight[i];
        item.age = item.age + 1;
        if (item.age < DEPTH && !(sb.flush && item.age < FLUSH_DEPTH)) nxt.push_back(item);
      end
      if (exp_issue && sb.id_writes_dest) begin
        item.age     = 0;
        item.dest    = int'(sb.id_dest);
        item.is_load = sb.id_is_load;
        nxt.push_back(item);
      end
      inflight = nxt;
      if (exp_stall && model_hc < 65535) model_hc++;
    end
  endtask

  // Compare process: check just after inputs settle, then advance the model at the edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        inflight.delete();
        model_hc = 0;
      end
      evalModel();
      checkOutput("model_issue", int'(sb.issue), int'(exp_issue));
      checkOutput("model_hazard_stall", int'(sb.hazard_stall), int'(exp_stall));
      checkOutput("model_fwd_sel_a", int'(sb.fwd_sel_a), exp_sel_a);
      checkOutput("model_fwd_sel_b", int'(sb.fwd_sel_b), exp_sel_b);
      checkOutput("model_busy_mask", int'(sb.busy_mask), exp_busy);
      checkOutput("model_hazard_cycles", int'(sb.hazard_cycles), model_hc);
      @(posedge clk);
      advanceModel();
    end
  end

  task automatic applyStimulus(input bit v, input int sr1, input bit u1, input int sr2,
                               input bit u2, input bit wr, input int dest, input bit ld,
                               input bit stall, input bit fl);
    @(negedge clk);
    sb.id_valid       = v;
    sb.id_sr1         = REG_W'(sr1);
    sb.id_uses_sr1    = u1;
    sb.id_sr2         = REG_W'(sr2);
    sb.id_uses_sr2    = u2;
    sb.id_writes_dest = wr;
    sb.id_dest        = REG_W'(dest);
    sb.id_is_load     = ld;
    sb.mem_stall      = stall;
    sb.flush          = fl;
    #3;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    sb.id_valid = 0; sb.id_sr1 = '0; sb.id_sr2 = '0; sb.id_uses_sr1 = 0;
    sb.id_uses_sr2 = 0; sb.id_writes_dest = 0; sb.id_dest = '0; sb.id_is_load = 0;
    sb.mem_stall = 0; sb.flush = 0;

    // Reset state: empty scoreboard, issue follows id_valid only.
    applyStimulus(1, 1, 1, 2, 1, 1, 3, 0, 0, 0);
    checkOutput("rst_issue", int'(sb.issue), 1);
    checkOutput("rst_hazard", int'(sb.hazard_stall), 0);
    checkOutput("rst_fwd_a", int'(sb.fwd_sel_a), 0);
    checkOutput("rst_fwd_b", int'(sb.fwd_sel_b), 0);
    checkOutput("rst_busy", int'(sb.busy_mask), 0);
    checkOutput("rst_hc", int'(sb.hazard_cycles), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back dependency on R1.
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 6, 0, 0, 0);
    checkOutput("b2b_fwd_a", int'(sb.fwd_sel_a), 1);
    checkOutput("b2b_hazard", int'(sb.hazard_stall), 0);
    checkOutput("b2b_issue", int'(sb.issue), 1);

    // Load-use on sr2: one interlock cycle, then forward from MEM.
    applyStimulus(1, 0, 1, 0, 0, 1, 2, 1, 0, 0);
    checkOutput("ldr_fwd_a_r0", int'(sb.fwd_sel_a), 0);
    applyStimulus(1, 0, 0, 2, 1, 1, 7, 0, 0, 0);
    checkOutput("lu_hazard", int'(sb.hazard_stall), 1);
    checkOutput("lu_issue", int'(sb.issue), 0);
    checkOutput("lu_fwd_b", int'(sb.fwd_sel_b), 1);
    applyStimulus(1, 0, 0, 2, 1, 1, 7, 0, 0, 0);
    checkOutput("lu2_hazard", int'(sb.hazard_stall), 0);
    checkOutput("lu2_issue", int'(sb.issue), 1);
    checkOutput("lu2_fwd_b", int'(sb.fwd_sel_b), 2);
    checkOutput("lu2_hc", int'(sb.hazard_cycles), 1);

    // Youngest wins: R3 in entries 2 and 0.
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(1, 3, 1, 3, 1, 1, 0, 0, 0, 0);
    checkOutput("yw_fwd_a", int'(sb.fwd_sel_a), 1);
    checkOutput("yw_fwd_b", int'(sb.fwd_sel_b), 1);
    checkOutput("yw_busy", int'(sb.busy_mask), 'h28);
    idle();
    checkOutput("yw_busy1", int'(sb.busy_mask), 'h29);
    idle();
    checkOutput("yw_busy2", int'(sb.busy_mask), 'h09);
    idle();
    checkOutput("yw_busy3", int'(sb.busy_mask), 'h01);

    // mem_stall for 5 cycles with a load-use pending.
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2, 1, 0, 0, 1, 4, 0, 1, 0);
      checkOutput("stall_hazard", int'(sb.hazard_stall), 1);
      checkOutput("stall_fwd_a", int'(sb.fwd_sel_a), 1);
      checkOutput("stall_hc", int'(sb.hazard_cycles), 1);
    end
    applyStimulus(1, 2, 1, 0, 0, 1, 4, 0, 0, 0);
    checkOutput("rel_hazard", int'(sb.hazard_stall), 1);
    checkOutput("rel_issue", int'(sb.issue), 0);
    applyStimulus(1, 2, 1, 0, 0, 1, 4, 0, 0, 0);
    checkOutput("rel2_issue", int'(sb.issue), 1);
    checkOutput("rel2_fwd_a", int'(sb.fwd_sel_a), 2);
    checkOutput("rel2_hc", int'(sb.hazard_cycles), 2);

    // Flush with R4 in EX and ADD R5 in ID.
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 1);
    checkOutput("fl_issue", int'(sb.issue), 0);
    checkOutput("fl_busy", int'(sb.busy_mask), 'h14);
    idle();
    checkOutput("fl_busy1", int'(sb.busy_mask), 'h10);
    idle();
    checkOutput("fl_busy2", int'(sb.busy_mask), 'h10);
    idle();
    checkOutput("fl_busy3", int'(sb.busy_mask), 0);

    // Flush masks a load-use interlock.
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 6, 0, 0, 1);
    checkOutput("flhz_hazard", int'(sb.hazard_stall), 0);
    checkOutput("flhz_issue", int'(sb.issue), 0);
    checkOutput("flhz_fwd_a", int'(sb.fwd_sel_a), 1);

    // id_valid = 0 raises no hazard even against a fresh load.
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 6, 0, 0, 0);
    checkOutput("nv_hazard", int'(sb.hazard_stall), 0);
    checkOutput("nv_issue", int'(sb.issue), 0);
    checkOutput("nv_busy", int'(sb.busy_mask), 'h02);

    // Three live entries, then asynchronous reset mid-cycle.
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(1, 1, 1, 2, 1, 1, 7, 0, 0, 0);
    checkOutput("pre_fwd_a", int'(sb.fwd_sel_a), 3);
    checkOutput("pre_fwd_b", int'(sb.fwd_sel_b), 2);
    checkOutput("pre_busy", int'(sb.busy_mask), 'h0E);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", int'(sb.busy_mask), 0);
    checkOutput("arst_fwd_a", int'(sb.fwd_sel_a), 0);
    checkOutput("arst_fwd_b", int'(sb.fwd_sel_b), 0);
    checkOutput("arst_hc", int'(sb.hazard_cycles), 0);
    checkOutput("arst_issue", int'(sb.issue), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 1, 1, 2, 1, 1, 7, 0, 0, 0);
    checkOutput("post_fwd_a", int'(sb.fwd_sel_a), 0);
    checkOutput("post_issue", int'(sb.issue), 1);
    applyStimulus(0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_fwd_a7", int'(sb.fwd_sel_a), 1);
    idle();

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
